// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_pkg
// Purpose  : Shared project types for the memory-access pipeline stage:
//            reset polarity, register write request, memory opcodes and
//            address-error exception codes.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

    // Reset status: the reset line is asserted when it equals RST_ENABLE.
    typedef logic reset_status_t;
    localparam reset_status_t RST_ENABLE  = 1'b0;
    localparam reset_status_t RST_DISABLE = 1'b1;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    // Register file write request.
    typedef struct packed {
        logic                  en;
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } reg_t;

    typedef enum logic [3:0] {
        MEM_NONE = 4'd0,
        MEM_LB   = 4'd1,
        MEM_LBU  = 4'd2,
        MEM_LH   = 4'd3,
        MEM_LHU  = 4'd4,
        MEM_LW   = 4'd5,
        MEM_SB   = 4'd6,
        MEM_SH   = 4'd7,
        MEM_SW   = 4'd8
    } mem_op_t;

    // MIPS-style cause codes for address errors on load / store.
    typedef enum logic [4:0] {
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5
    } exc_code_t;

    function automatic logic is_store(input mem_op_t op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_if
// Purpose  : Single-outstanding data-bus handshake between the memory stage
//            (master) and the memory / interconnect (slave).
// Ports    : req, we, addr (word aligned), be, wdata  : master -> slave
//            ack, rdata (valid with ack)               : slave  -> master
// Revision : 1.0 - initial release
// ============================================================================
interface mem_stage_if #(
    parameter int ADDR_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        be;
    logic [31:0]       wdata;
    logic              ack;
    logic [31:0]       rdata;

    modport master (output req, we, addr, be, wdata, input ack, rdata);
    modport slave  (input req, we, addr, be, wdata, output ack, rdata);
endinterface
`default_nettype wire

// File: rtl/mem_stage_align.sv
`default_nettype none
// ============================================================================
// Module   : mem_align
// Purpose  : Combinational byte-lane steering for the memory stage. Produces
//            store byte enables and lane-replicated write data, the
//            sign/zero-extended load result, and the misalignment flag.
// Ports    : op_i          memory opcode
//            addr_lo_i     byte offset within the word
//            store_data_i  rt value for stores
//            rdata_i       read word from the bus
//            be_o          byte enables (loads always 4'b1111)
//            wdata_o       lane-replicated store data
//            load_data_o   extended load result
//            misalign_o    access not naturally aligned
// Revision : 1.0 - initial release
// ============================================================================
module mem_align
    import mem_stage_pkg::*;
(
    input  mem_op_t     op_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_data_o,
    output logic        misalign_o
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    always_comb begin
        rd_byte = rdata_i[{addr_lo_i, 3'b000} +: 8];
        rd_half = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    always_comb begin
        be_o        = 4'b0000;
        wdata_o     = store_data_i;
        load_data_o = 32'h0;
        misalign_o  = 1'b0;
        case (op_i)
            MEM_LB: begin
                be_o        = 4'b1111;
                load_data_o = {{24{rd_byte[7]}}, rd_byte};
            end
            MEM_LBU: begin
                be_o        = 4'b1111;
                load_data_o = {24'h0, rd_byte};
            end
            MEM_LH: begin
                be_o        = 4'b1111;
                load_data_o = {{16{rd_half[15]}}, rd_half};
                misalign_o  = addr_lo_i[0];
            end
            MEM_LHU: begin
                be_o        = 4'b1111;
                load_data_o = {16'h0, rd_half};
                misalign_o  = addr_lo_i[0];
            end
            MEM_LW: begin
                be_o        = 4'b1111;
                load_data_o = rdata_i;
                misalign_o  = |addr_lo_i;
            end
            MEM_SB: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{store_data_i[7:0]}};
            end
            MEM_SH: begin
                be_o       = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o    = {2{store_data_i[15:0]}};
                misalign_o = addr_lo_i[0];
            end
            MEM_SW: begin
                be_o       = 4'b1111;
                misalign_o = |addr_lo_i;
            end
            default: begin
                be_o = 4'b0000;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Purpose  : Memory-access pipeline stage between execute and writeback.
//            Accepts one instruction per EX handshake, runs loads/stores over
//            a single-outstanding data bus, and presents a registered
//            register-file write request. Misaligned accesses raise an
//            address-error exception instead of a bus request.
// Ports    : clk, rst_n                 clock, async active-low reset
//            ex_valid_i / ex_ready_o    EX handshake (ready only in IDLE)
//            ex_wreg_i, ex_mem_op_i,
//            ex_mem_addr_i,
//            ex_store_data_i            instruction payload from EX
//            flush_i                    discard in-flight result
//            dbus                       data-bus master port
//            wb_wreg_o                  registered writeback request
//            exc_valid_o, exc_code_o,
//            exc_badaddr_o              registered address-error report
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  reset_status_t     rst_n,
    input  logic              ex_valid_i,
    output logic              ex_ready_o,
    input  reg_t              ex_wreg_i,
    input  mem_op_t           ex_mem_op_i,
    input  logic [ADDR_W-1:0] ex_mem_addr_i,
    input  logic [31:0]       ex_store_data_i,
    input  logic              flush_i,
    mem_stage_if.master       dbus,
    output reg_t              wb_wreg_o,
    output logic              exc_valid_o,
    output exc_code_t         exc_code_o,
    output logic [ADDR_W-1:0] exc_badaddr_o
);

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_WAIT_ACK = 1'b1
    } state_t;

    state_t                  state_q;
    mem_op_t                 op_q;
    logic [1:0]              addr_lo_q;
    logic                    dest_en_q;
    logic [REG_ADDR_W-1:0]   dest_addr_q;
    logic                    kill_q;
    logic                    req_q;
    logic                    we_q;
    logic [ADDR_W-1:0]       addr_q;
    logic [3:0]              be_q;
    logic [31:0]             wdata_q;
    reg_t                    wb_q;
    logic                    exc_valid_q;
    exc_code_t               exc_code_q;
    logic [ADDR_W-1:0]       badaddr_q;

    // The single aligner serves the EX op while idle (store steering and the
    // misalign check at accept) and the latched op while waiting (load
    // extraction at ack).
    mem_op_t     align_op;
    logic [1:0]  align_lo;
    logic [3:0]  align_be;
    logic [31:0] align_wdata;
    logic [31:0] align_load;
    logic        align_misalign;

    always_comb begin
        align_op = (state_q == ST_IDLE) ? ex_mem_op_i : op_q;
        align_lo = (state_q == ST_IDLE) ? ex_mem_addr_i[1:0] : addr_lo_q;
    end

    mem_align u_align (
        .op_i         (align_op),
        .addr_lo_i    (align_lo),
        .store_data_i (ex_store_data_i),
        .rdata_i      (dbus.rdata),
        .be_o         (align_be),
        .wdata_o      (align_wdata),
        .load_data_o  (align_load),
        .misalign_o   (align_misalign)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n == RST_ENABLE) begin
            state_q     <= ST_IDLE;
            op_q        <= MEM_NONE;
            addr_lo_q   <= 2'b00;
            dest_en_q   <= 1'b0;
            dest_addr_q <= '0;
            kill_q      <= 1'b0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            be_q        <= 4'b0000;
            wdata_q     <= 32'h0;
            wb_q        <= '0;
            exc_valid_q <= 1'b0;
            exc_code_q  <= EXC_ADEL;
            badaddr_q   <= '0;
        end else begin
            // Exceptions are single-cycle pulses.
            exc_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    wb_q.en <= 1'b0;
                    // A flush in IDLE drops the offered instruction entirely.
                    if (ex_valid_i && !flush_i) begin
                        if (ex_mem_op_i == MEM_NONE) begin
                            wb_q <= ex_wreg_i;
                        end else if (align_misalign) begin
                            exc_valid_q <= 1'b1;
                            exc_code_q  <= is_store(ex_mem_op_i) ? EXC_ADES : EXC_ADEL;
                            badaddr_q   <= ex_mem_addr_i;
                        end else begin
                            op_q        <= ex_mem_op_i;
                            addr_lo_q   <= ex_mem_addr_i[1:0];
                            dest_en_q   <= ex_wreg_i.en;
                            dest_addr_q <= ex_wreg_i.addr;
                            kill_q      <= 1'b0;
                            req_q       <= 1'b1;
                            we_q        <= is_store(ex_mem_op_i);
                            addr_q      <= {ex_mem_addr_i[ADDR_W-1:2], 2'b00};
                            be_q        <= align_be;
                            wdata_q     <= align_wdata;
                            state_q     <= ST_WAIT_ACK;
                        end
                    end
                end
                ST_WAIT_ACK: begin
                    if (flush_i) begin
                        kill_q <= 1'b1;
                    end
                    if (dbus.ack) begin
                        req_q   <= 1'b0;
                        kill_q  <= 1'b0;
                        state_q <= ST_IDLE;
                        if (!is_store(op_q)) begin
                            // A flush coinciding with the ack still kills.
                            wb_q.en   <= dest_en_q & ~(kill_q | flush_i);
                            wb_q.addr <= dest_addr_q;
                            wb_q.data <= align_load;
                        end else begin
                            wb_q.en <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ex_ready_o    = (state_q == ST_IDLE);
    assign dbus.req      = req_q;
    assign dbus.we       = we_q;
    assign dbus.addr     = addr_q;
    assign dbus.be       = be_q;
    assign dbus.wdata    = wdata_q;
    assign wb_wreg_o     = wb_q;
    assign exc_valid_o   = exc_valid_q;
    assign exc_code_o    = exc_code_q;
    assign exc_badaddr_o = badaddr_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage
// Purpose  : Self-checking bench for mem_stage. Directed stimulus pushes the
//            hand-computed bus request, writeback and exception it expects;
//            a monitor pops and compares whenever the DUT presents one.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic          clk = 1'b0;
    reset_status_t rst_n;
    logic          ex_valid;
    logic          ex_ready;
    reg_t          ex_wreg;
    mem_op_t       ex_mem_op;
    logic [31:0]   ex_mem_addr;
    logic [31:0]   ex_store_data;
    logic          flush;
    reg_t          wb_wreg;
    logic          exc_valid;
    exc_code_t     exc_code;
    logic [31:0]   exc_badaddr;

    always #5 clk = ~clk;

    mem_stage_if #(.ADDR_W(32)) dbus ();

    mem_stage #(.ADDR_W(32)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ex_valid_i      (ex_valid),
        .ex_ready_o      (ex_ready),
        .ex_wreg_i       (ex_wreg),
        .ex_mem_op_i     (ex_mem_op),
        .ex_mem_addr_i   (ex_mem_addr),
        .ex_store_data_i (ex_store_data),
        .flush_i         (flush),
        .dbus            (dbus),
        .wb_wreg_o       (wb_wreg),
        .exc_valid_o     (exc_valid),
        .exc_code_o      (exc_code),
        .exc_badaddr_o   (exc_badaddr)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        chk_wdata;
    } bus_exp_t;
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_exp_t;
    typedef struct {
        exc_code_t   code;
        logic [31:0] bad;
    } exc_exp_t;

    bus_exp_t bus_q[$];
    wb_exp_t  wb_q[$];
    exc_exp_t exc_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic exp_bus(input logic [31:0] a, input logic we, input logic [3:0] be,
                           input logic [31:0] wd, input logic cw);
        bus_exp_t e;
        e.addr = a; e.we = we; e.be = be; e.wdata = wd; e.chk_wdata = cw;
        bus_q.push_back(e);
    endtask

    task automatic exp_wb(input logic [4:0] rd, input logic [31:0] d);
        wb_exp_t e;
        e.rd = rd; e.data = d;
        wb_q.push_back(e);
    endtask

    task automatic exp_exc(input exc_code_t c, input logic [31:0] b);
        exc_exp_t e;
        e.code = c; e.bad = b;
        exc_q.push_back(e);
    endtask

    function automatic reg_t mkreg(input logic en, input logic [4:0] a, input logic [31:0] d);
        reg_t r;
        r.en = en; r.addr = a; r.data = d;
        return r;
    endfunction

    // ---------------------------------------------------------------- monitor
    logic     prev_req = 1'b0;
    logic     bus_cur_ok = 1'b0;
    bus_exp_t bus_cur;

    always @(negedge clk) begin
        if (dbus.req) begin
            if (!prev_req) begin
                if (bus_q.size() == 0) begin
                    checks++;
                    errors++;
                    bus_cur_ok = 1'b0;
                    $display("FAIL unexpected_dbus_req: got addr %h we %b, required no request",
                             dbus.addr, dbus.we);
                end else begin
                    bus_cur    = bus_q.pop_front();
                    bus_cur_ok = 1'b1;
                end
            end
            if (bus_cur_ok) begin
                chk("dbus_addr", 64'(dbus.addr), 64'(bus_cur.addr));
                chk("dbus_we",   64'(dbus.we),   64'(bus_cur.we));
                chk("dbus_be",   64'(dbus.be),   64'(bus_cur.be));
                if (bus_cur.chk_wdata)
                    chk("dbus_wdata", 64'(dbus.wdata), 64'(bus_cur.wdata));
            end
        end
        prev_req = dbus.req;

        if (wb_wreg.en) begin
            if (wb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_wb: got rd %0d data %h, required no writeback",
                         wb_wreg.addr, wb_wreg.data);
            end else begin
                wb_exp_t w;
                w = wb_q.pop_front();
                chk("wb_addr", 64'(wb_wreg.addr), 64'(w.rd));
                chk("wb_data", 64'(wb_wreg.data), 64'(w.data));
            end
        end

        if (exc_valid) begin
            if (exc_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_exc: got code %0d badaddr %h, required none",
                         exc_code, exc_badaddr);
            end else begin
                exc_exp_t x;
                x = exc_q.pop_front();
                chk("exc_code",    64'(exc_code),    64'(x.code));
                chk("exc_badaddr", 64'(exc_badaddr), 64'(x.bad));
            end
        end
    end

    // --------------------------------------------------------------- stimulus
    task automatic issue(input mem_op_t op, input reg_t w, input logic [31:0] a,
                         input logic [31:0] sd);
        int k;
        k = 0;
        while (!ex_ready && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        if (!ex_ready) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: got ex_ready %b required 1", ex_ready);
        end
        ex_valid      = 1'b1;
        ex_mem_op     = op;
        ex_wreg       = w;
        ex_mem_addr   = a;
        ex_store_data = sd;
        @(posedge clk); #1;
        ex_valid      = 1'b0;
        ex_mem_op     = MEM_NONE;
        ex_wreg       = '0;
    endtask

    // Issue a memory op, hold ack off for nwait cycles, then ack with rdata.
    // flush_at selects the wait cycle (0-based) in which flush is pulsed.
    task automatic mem_txn(input mem_op_t op, input logic [31:0] a, input logic [31:0] sd,
                           input logic [4:0] rd, input int nwait, input logic [31:0] rdata,
                           input int flush_at);
        int low;
        issue(op, mkreg(1'b1, rd, 32'h0), a, sd);
        chk("req_after_accept", 64'(dbus.req), 64'd1);
        low = 0;
        for (int i = 0; i < nwait; i++) begin
            if (!ex_ready) low++;
            if (i == flush_at) flush = 1'b1;
            @(posedge clk); #1;
            flush = 1'b0;
        end
        if (!ex_ready) low++;
        dbus.ack   = 1'b1;
        dbus.rdata = rdata;
        @(posedge clk); #1;
        dbus.ack   = 1'b0;
        dbus.rdata = 32'h5A5A_5A5A;
        chk("ready_low_cycles", 64'(low), 64'(nwait + 1));
        chk("ready_after_ack",  64'(ex_ready), 64'd1);
        chk("req_after_ack",    64'(dbus.req), 64'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"},   64'(dbus.req),   64'd0);
        chk({tag, "_we"},    64'(dbus.we),    64'd0);
        chk({tag, "_be"},    64'(dbus.be),    64'd0);
        chk({tag, "_addr"},  64'(dbus.addr),  64'd0);
        chk({tag, "_wdata"}, 64'(dbus.wdata), 64'd0);
        chk({tag, "_wb"},    64'(wb_wreg),    64'd0);
        chk({tag, "_exc"},   64'(exc_valid),  64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n         = RST_ENABLE;
        ex_valid      = 1'b0;
        ex_wreg       = '0;
        ex_mem_op     = MEM_NONE;
        ex_mem_addr   = 32'h0;
        ex_store_data = 32'h0;
        flush         = 1'b0;
        dbus.ack      = 1'b0;
        dbus.rdata    = 32'h0;

        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = RST_DISABLE;
        #1;
        chk("reset_ready", 64'(ex_ready), 64'd1);
        @(posedge clk); #1;

        // ALU passthrough
        exp_wb(5'd3, 32'h0000_1234);
        issue(MEM_NONE, mkreg(1'b1, 5'd3, 32'h0000_1234), 32'h0, 32'h0);
        chk("alu_wb_en", 64'(wb_wreg.en), 64'd1);
        chk("alu_no_req", 64'(dbus.req), 64'd0);
        @(posedge clk); #1;
        chk("alu_bubble_en", 64'(wb_wreg.en), 64'd0);

        // Loads from word 0x1000 = 0x80FF_7F00
        exp_bus(32'h1000, 1'b0, 4'b1111, 32'h0, 1'b0);
        exp_wb(5'd7, 32'hFFFF_FFFF);
        mem_txn(MEM_LB, 32'h1002, 32'h0, 5'd7, 2, 32'h80FF_7F00, -1);

        exp_bus(32'h1000, 1'b0, 4'b1111, 32'h0, 1'b0);
        exp_wb(5'd8, 32'h0000_00FF);
        mem_txn(MEM_LBU, 32'h1002, 32'h0, 5'd8, 2, 32'h80FF_7F00, -1);

        exp_bus(32'h1000, 1'b0, 4'b1111, 32'h0, 1'b0);
        exp_wb(5'd9, 32'hFFFF_80FF);
        mem_txn(MEM_LH, 32'h1002, 32'h0, 5'd9, 0, 32'h80FF_7F00, -1);

        exp_bus(32'h1000, 1'b0, 4'b1111, 32'h0, 1'b0);
        exp_wb(5'd10, 32'h0000_7F00);
        mem_txn(MEM_LHU, 32'h1000, 32'h0, 5'd10, 1, 32'h80FF_7F00, -1);

        exp_bus(32'h1000, 1'b0, 4'b1111, 32'h0, 1'b0);
        exp_wb(5'd11, 32'h0000_007F);
        mem_txn(MEM_LB, 32'h1001, 32'h0, 5'd11, 0, 32'h80FF_7F00, -1);

        exp_bus(32'h1000, 1'b0, 4'b1111, 32'h0, 1'b0);
        exp_wb(5'd0, 32'h80FF_7F00);
        mem_txn(MEM_LW, 32'h1000, 32'h0, 5'd0, 3, 32'h80FF_7F00, -1);

        // Stores
        exp_bus(32'h2000, 1'b1, 4'b1100, 32'hBEEF_BEEF, 1'b1);
        mem_txn(MEM_SH, 32'h2002, 32'h0000_BEEF, 5'd12, 1, 32'h0, -1);
        chk("sh_wb_en", 64'(wb_wreg.en), 64'd0);

        exp_bus(32'h2000, 1'b1, 4'b0011, 32'hCAFE_CAFE, 1'b1);
        mem_txn(MEM_SH, 32'h2000, 32'h1234_CAFE, 5'd12, 0, 32'h0, -1);

        exp_bus(32'h2000, 1'b1, 4'b0010, 32'h7878_7878, 1'b1);
        mem_txn(MEM_SB, 32'h2001, 32'h1234_5678, 5'd12, 0, 32'h0, -1);

        exp_bus(32'h3000, 1'b1, 4'b1000, 32'hA5A5_A5A5, 1'b1);
        mem_txn(MEM_SB, 32'h3003, 32'h0000_00A5, 5'd12, 1, 32'h0, -1);

        exp_bus(32'h2004, 1'b1, 4'b1111, 32'hCAFE_F00D, 1'b1);
        mem_txn(MEM_SW, 32'h2004, 32'hCAFE_F00D, 5'd12, 0, 32'h0, -1);
        chk("sw_wb_en", 64'(wb_wreg.en), 64'd0);

        // Misaligned accesses: exception pulse, no bus request
        exp_exc(EXC_ADEL, 32'h3001);
        issue(MEM_LW, mkreg(1'b1, 5'd13, 32'h0), 32'h3001, 32'h0);
        chk("adel_ready", 64'(ex_ready), 64'd1);
        chk("adel_wb_en", 64'(wb_wreg.en), 64'd0);
        @(posedge clk); #1;
        chk("adel_pulse_end", 64'(exc_valid), 64'd0);

        exp_exc(EXC_ADES, 32'h3002);
        issue(MEM_SW, mkreg(1'b1, 5'd13, 32'h0), 32'h3002, 32'h1111_1111);
        @(posedge clk); #1;
        exp_exc(EXC_ADEL, 32'h3003);
        issue(MEM_LH, mkreg(1'b1, 5'd13, 32'h0), 32'h3003, 32'h0);
        @(posedge clk); #1;
        exp_exc(EXC_ADES, 32'h3001);
        issue(MEM_SH, mkreg(1'b1, 5'd13, 32'h0), 32'h3001, 32'h2222_2222);
        @(posedge clk); #1;
        exp_exc(EXC_ADEL, 32'h3005);
        issue(MEM_LHU, mkreg(1'b1, 5'd13, 32'h0), 32'h3005, 32'h0);
        @(posedge clk); #1;

        // Flush in IDLE drops the instruction: no exception, no writeback
        flush = 1'b1;
        issue(MEM_LW, mkreg(1'b1, 5'd13, 32'h0), 32'h3001, 32'h0);
        issue(MEM_NONE, mkreg(1'b1, 5'd4, 32'h0000_0044), 32'h0, 32'h0);
        flush = 1'b0;
        chk("flush_idle_ready", 64'(ex_ready), 64'd1);
        chk("flush_idle_wb", 64'(wb_wreg.en), 64'd0);

        // Flush during WAIT_ACK: transaction completes, result killed
        exp_bus(32'h4000, 1'b0, 4'b1111, 32'h0, 1'b0);
        mem_txn(MEM_LW, 32'h4000, 32'h0, 5'd14, 3, 32'hDEAD_BEEF, 1);
        chk("flush_wait_wb_en", 64'(wb_wreg.en), 64'd0);

        exp_bus(32'h4004, 1'b0, 4'b1111, 32'h0, 1'b0);
        exp_wb(5'd15, 32'h1234_5678);
        mem_txn(MEM_LW, 32'h4004, 32'h0, 5'd15, 0, 32'h1234_5678, -1);

        // Ack while idle is ignored
        dbus.ack   = 1'b1;
        dbus.rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        dbus.ack   = 1'b0;
        chk("idle_ack_wb", 64'(wb_wreg.en), 64'd0);
        chk("idle_ack_req", 64'(dbus.req), 64'd0);
        chk("idle_ack_ready", 64'(ex_ready), 64'd1);

        // Reset during WAIT_ACK drops the request at once
        exp_bus(32'h5000, 1'b0, 4'b1111, 32'h0, 1'b0);
        issue(MEM_LW, mkreg(1'b1, 5'd16, 32'h0), 32'h5000, 32'h0);
        @(negedge clk); #1;
        rst_n = RST_ENABLE;
        #1;
        chk_reset_outputs("midrst");
        @(posedge clk); #1;
        rst_n = RST_DISABLE;
        #1;
        chk("midrst_ready", 64'(ex_ready), 64'd1);

        exp_bus(32'h5000, 1'b0, 4'b1111, 32'h0, 1'b0);
        exp_wb(5'd17, 32'h0000_00AB);
        mem_txn(MEM_LBU, 32'h5003, 32'h0, 5'd17, 1, 32'hAB00_0000, -1);

        repeat (5) @(posedge clk);
        #1;
        chk("bus_queue_empty", 64'(bus_q.size()), 64'd0);
        chk("wb_queue_empty",  64'(wb_q.size()),  64'd0);
        chk("exc_queue_empty", 64'(exc_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
